// File: rtl/issue_operand_stage_if.sv
// Issue-side, register-file, writeback-bypass and execute-side signals of the operand stage.
// The stage connects through the slave modport; the surrounding pipeline uses master.
interface issue_operand_stage_if #(
    parameter int PHY_REG_NUM = 64,
    parameter int WB_WIDTH    = 4,
    parameter int DATA_W      = 32,
    parameter int OC_W        = 16
);
    localparam int PREG_W = (PHY_REG_NUM > 1) ? $clog2(PHY_REG_NUM) : 1;

    logic                         issue_valid_i;
    logic                         issue_ready_o;
    logic [PREG_W-1:0]            issue_psrc0_i;
    logic [PREG_W-1:0]            issue_psrc1_i;
    logic                         issue_psrc0_valid_i;
    logic                         issue_psrc1_valid_i;
    logic [PREG_W-1:0]            issue_pdest_i;
    logic [OC_W-1:0]              issue_oc_i;

    logic [PREG_W-1:0]            rf_raddr0_o;
    logic [PREG_W-1:0]            rf_raddr1_o;
    logic [DATA_W-1:0]            rf_rdata0_i;
    logic [DATA_W-1:0]            rf_rdata1_i;

    logic [WB_WIDTH-1:0]          wb_i;
    logic [WB_WIDTH*PREG_W-1:0]   wb_pdest_i;
    logic [WB_WIDTH*DATA_W-1:0]   wb_data_i;

    logic                         exe_valid_o;
    logic                         exe_ready_i;
    logic [DATA_W-1:0]            exe_src0_o;
    logic [DATA_W-1:0]            exe_src1_o;
    logic [PREG_W-1:0]            exe_pdest_o;
    logic [OC_W-1:0]              exe_oc_o;

    modport slave (
        input  issue_valid_i, issue_psrc0_i, issue_psrc1_i, issue_psrc0_valid_i,
               issue_psrc1_valid_i, issue_pdest_i, issue_oc_i,
               rf_rdata0_i, rf_rdata1_i, wb_i, wb_pdest_i, wb_data_i, exe_ready_i,
        output issue_ready_o, rf_raddr0_o, rf_raddr1_o,
               exe_valid_o, exe_src0_o, exe_src1_o, exe_pdest_o, exe_oc_o
    );

    modport master (
        output issue_valid_i, issue_psrc0_i, issue_psrc1_i, issue_psrc0_valid_i,
               issue_psrc1_valid_i, issue_pdest_i, issue_oc_i,
               rf_rdata0_i, rf_rdata1_i, wb_i, wb_pdest_i, wb_data_i, exe_ready_i,
        input  issue_ready_o, rf_raddr0_o, rf_raddr1_o,
               exe_valid_o, exe_src0_o, exe_src1_o, exe_pdest_o, exe_oc_o
    );
endinterface

// File: rtl/issue_operand_stage.sv
// Operand-read stage between reservation station and execute: captures operands with
// writeback bypass, then holds them in a main register plus one skid entry.
module issue_operand_stage #(
    parameter int PHY_REG_NUM = 64,
    parameter int WB_WIDTH    = 4,
    parameter int DATA_W      = 32,
    parameter int OC_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    issue_operand_stage_if.slave bus
);
    localparam int PREG_W = (PHY_REG_NUM > 1) ? $clog2(PHY_REG_NUM) : 1;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] src0;
        logic [DATA_W-1:0] src1;
        logic [PREG_W-1:0] pdest;
        logic [OC_W-1:0]   oc;
    } entry_t;

    entry_t m_q, m_d;
    entry_t s_q, s_d;
    entry_t new_ent;
    logic   accept;
    logic   drain;

    // Lowest-numbered matching writeback port wins, so scan from the top down.
    function automatic logic [DATA_W-1:0] pick_operand(
        input logic                       used,
        input logic [PREG_W-1:0]          psrc,
        input logic [DATA_W-1:0]          rf_data,
        input logic [WB_WIDTH-1:0]        wb,
        input logic [WB_WIDTH*PREG_W-1:0] wb_pdest,
        input logic [WB_WIDTH*DATA_W-1:0] wb_data
    );
        logic [DATA_W-1:0] res;
        res = rf_data;
        for (int j = WB_WIDTH - 1; j >= 0; j--) begin
            if (wb[j] && (wb_pdest[j*PREG_W +: PREG_W] == psrc)) begin
                res = wb_data[j*DATA_W +: DATA_W];
            end
        end
        if (!used) begin
            res = '0;
        end
        return res;
    endfunction

    assign bus.rf_raddr0_o   = bus.issue_psrc0_i;
    assign bus.rf_raddr1_o   = bus.issue_psrc1_i;
    assign bus.issue_ready_o = ~s_q.valid;

    assign bus.exe_valid_o = m_q.valid;
    assign bus.exe_src0_o  = m_q.src0;
    assign bus.exe_src1_o  = m_q.src1;
    assign bus.exe_pdest_o = m_q.pdest;
    assign bus.exe_oc_o    = m_q.oc;

    assign accept = bus.issue_valid_i & ~s_q.valid;
    assign drain  = m_q.valid & bus.exe_ready_i;

    always_comb begin
        new_ent       = '0;
        new_ent.valid = 1'b1;
        new_ent.src0  = pick_operand(bus.issue_psrc0_valid_i, bus.issue_psrc0_i, bus.rf_rdata0_i,
                                     bus.wb_i, bus.wb_pdest_i, bus.wb_data_i);
        new_ent.src1  = pick_operand(bus.issue_psrc1_valid_i, bus.issue_psrc1_i, bus.rf_rdata1_i,
                                     bus.wb_i, bus.wb_pdest_i, bus.wb_data_i);
        new_ent.pdest = bus.issue_pdest_i;
        new_ent.oc    = bus.issue_oc_i;
    end

    // A full skid entry blocks accepts, so the skid-refill and accept paths never overlap.
    always_comb begin
        m_d = m_q;
        s_d = s_q;
        if (flush_i) begin
            m_d.valid = 1'b0;
            s_d.valid = 1'b0;
        end else if (s_q.valid) begin
            if (drain) begin
                m_d       = s_q;
                s_d.valid = 1'b0;
            end
        end else if (!m_q.valid || drain) begin
            if (accept) begin
                m_d = new_ent;
            end else begin
                m_d.valid = 1'b0;
            end
        end else if (accept) begin
            s_d = new_ent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            m_q <= m_d;
            s_q <= s_d;
        end
    end
endmodule

// File: tb/tb_issue_operand_stage.sv
// Bench for issue_operand_stage: operand-select vector table, directed handshake
// sequences, and a randomized run against a two-deep FIFO reference model.
module tb_issue_operand_stage;
    localparam int PHY_REG_NUM = 64;
    localparam int WB_WIDTH    = 4;
    localparam int DATA_W      = 32;
    localparam int OC_W        = 16;
    localparam int PREG_W      = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_i = 1'b0;

    always #5 clk = ~clk;

    issue_operand_stage_if #(
        .PHY_REG_NUM(PHY_REG_NUM), .WB_WIDTH(WB_WIDTH), .DATA_W(DATA_W), .OC_W(OC_W)
    ) bus ();

    issue_operand_stage #(
        .PHY_REG_NUM(PHY_REG_NUM), .WB_WIDTH(WB_WIDTH), .DATA_W(DATA_W), .OC_W(OC_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush_i(flush_i),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [PREG_W-1:0]                 p0;
        logic                              v0;
        logic [PREG_W-1:0]                 p1;
        logic                              v1;
        logic [DATA_W-1:0]                 rf0;
        logic [DATA_W-1:0]                 rf1;
        logic [WB_WIDTH-1:0]               wb;
        logic [WB_WIDTH-1:0][PREG_W-1:0]   wbp;
        logic [WB_WIDTH-1:0][DATA_W-1:0]   wbd;
        logic [PREG_W-1:0]                 pdest;
        logic [OC_W-1:0]                   oc;
        logic [DATA_W-1:0]                 exp0;
        logic [DATA_W-1:0]                 exp1;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] s0;
        logic [DATA_W-1:0] s1;
        logic [PREG_W-1:0] pd;
        logic [OC_W-1:0]   oc;
    } ent_t;

    vec_t vecs[$];
    ent_t model_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.issue_valid_i       = 1'b0;
        bus.issue_psrc0_i       = '0;
        bus.issue_psrc1_i       = '0;
        bus.issue_psrc0_valid_i = 1'b0;
        bus.issue_psrc1_valid_i = 1'b0;
        bus.issue_pdest_i       = '0;
        bus.issue_oc_i          = '0;
        bus.rf_rdata0_i         = '0;
        bus.rf_rdata1_i         = '0;
        bus.wb_i                = '0;
        bus.wb_pdest_i          = '0;
        bus.wb_data_i           = '0;
        bus.exe_ready_i         = 1'b1;
    endtask

    task automatic offer(input logic [OC_W-1:0] oc, input logic [DATA_W-1:0] d0);
        bus.issue_valid_i       = 1'b1;
        bus.issue_psrc0_i       = 6'd5;
        bus.issue_psrc0_valid_i = 1'b1;
        bus.rf_rdata0_i         = d0;
        bus.issue_oc_i          = oc;
    endtask

    // Operand rule stated directly: unused -> 0, else first matching writeback port, else RF.
    function automatic logic [DATA_W-1:0] ref_operand(input logic used, input logic [PREG_W-1:0] psrc,
                                                      input logic [DATA_W-1:0] rf);
        if (!used) return '0;
        for (int j = 0; j < WB_WIDTH; j++) begin
            if (bus.wb_i[j] && bus.wb_pdest_i[j*PREG_W +: PREG_W] == psrc)
                return bus.wb_data_i[j*DATA_W +: DATA_W];
        end
        return rf;
    endfunction

    initial begin
        vec_t v;
        ent_t e;
        logic acc;
        logic drn;

        idle_inputs();
        #1;
        check("reset_exe_valid", bus.exe_valid_o, 0);
        check("reset_issue_ready", bus.issue_ready_o, 1);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_exe_valid", bus.exe_valid_o, 0);
        check("post_reset_issue_ready", bus.issue_ready_o, 1);
        check("post_reset_src0", bus.exe_src0_o, 0);

        v = '{default: '0};
        v.p0 = 6'd5; v.v0 = 1; v.p1 = 6'd9; v.v1 = 1; v.rf0 = 32'hAAAA; v.rf1 = 32'hBBBB;
        v.pdest = 6'd17; v.oc = 16'h1111; v.exp0 = 32'hAAAA; v.exp1 = 32'hBBBB;
        vecs.push_back(v);
        v = '{default: '0};
        v.p0 = 6'd3; v.v0 = 1; v.p1 = 6'd9; v.v1 = 1; v.rf0 = 32'h1234; v.rf1 = 32'h9999;
        v.wb = 4'b0110; v.wbp[1] = 6'd9; v.wbp[2] = 6'd9; v.wbd[1] = 32'h11; v.wbd[2] = 32'h22;
        v.pdest = 6'd2; v.oc = 16'h2222; v.exp0 = 32'h1234; v.exp1 = 32'h11;
        vecs.push_back(v);
        v = '{default: '0};
        v.p0 = 6'd0; v.v0 = 0; v.p1 = 6'd7; v.v1 = 1; v.rf0 = 32'hFFFF; v.rf1 = 32'h77;
        v.pdest = 6'd63; v.oc = 16'hFFFF; v.exp0 = 32'h0; v.exp1 = 32'h77;
        vecs.push_back(v);
        v = '{default: '0};
        v.p0 = 6'd5; v.v0 = 1; v.p1 = 6'd4; v.v1 = 1; v.rf0 = 32'h5555; v.rf1 = 32'h4444;
        v.wb = 4'b0001; v.wbp[0] = 6'd4; v.wbp[3] = 6'd5; v.wbd[0] = 32'hCAFE; v.wbd[3] = 32'hDEAD;
        v.pdest = 6'd8; v.oc = 16'h0404; v.exp0 = 32'h5555; v.exp1 = 32'hCAFE;
        vecs.push_back(v);
        v = '{default: '0};
        v.p0 = 6'd12; v.v0 = 1; v.p1 = 6'd12; v.v1 = 0; v.rf0 = 32'h1; v.rf1 = 32'h2;
        v.wb = 4'b1000; v.wbp[3] = 6'd12; v.wbd[3] = 32'h3333;
        v.pdest = 6'd12; v.oc = 16'h0C0C; v.exp0 = 32'h3333; v.exp1 = 32'h0;
        vecs.push_back(v);

        foreach (vecs[i]) begin
            bus.issue_valid_i       = 1'b1;
            bus.issue_psrc0_i       = vecs[i].p0;
            bus.issue_psrc0_valid_i = vecs[i].v0;
            bus.issue_psrc1_i       = vecs[i].p1;
            bus.issue_psrc1_valid_i = vecs[i].v1;
            bus.rf_rdata0_i         = vecs[i].rf0;
            bus.rf_rdata1_i         = vecs[i].rf1;
            bus.wb_i                = vecs[i].wb;
            bus.wb_pdest_i          = vecs[i].wbp;
            bus.wb_data_i           = vecs[i].wbd;
            bus.issue_pdest_i       = vecs[i].pdest;
            bus.issue_oc_i          = vecs[i].oc;
            bus.exe_ready_i         = 1'b1;
            #1;
            check($sformatf("vec%0d_raddr0", i), bus.rf_raddr0_o, vecs[i].p0);
            check($sformatf("vec%0d_raddr1", i), bus.rf_raddr1_o, vecs[i].p1);
            step();
            idle_inputs();
            check($sformatf("vec%0d_valid", i), bus.exe_valid_o, 1);
            check($sformatf("vec%0d_src0", i), bus.exe_src0_o, vecs[i].exp0);
            check($sformatf("vec%0d_src1", i), bus.exe_src1_o, vecs[i].exp1);
            check($sformatf("vec%0d_pdest", i), bus.exe_pdest_o, vecs[i].pdest);
            check($sformatf("vec%0d_oc", i), bus.exe_oc_o, vecs[i].oc);
            step();
            check($sformatf("vec%0d_drained", i), bus.exe_valid_o, 0);
        end

        // Back-to-back stream, one per cycle.
        for (int k = 1; k <= 8; k++) begin
            offer(16'(k), 32'hAAAA);
            step();
            check($sformatf("stream%0d_valid", k), bus.exe_valid_o, 1);
            check($sformatf("stream%0d_oc", k), bus.exe_oc_o, k);
            check($sformatf("stream%0d_src0", k), bus.exe_src0_o, 32'hAAAA);
            check($sformatf("stream%0d_ready", k), bus.issue_ready_o, 1);
        end
        idle_inputs();
        step();
        check("stream_end_valid", bus.exe_valid_o, 0);

        // Backpressure: A lands in main, B in skid, then both drain in order.
        bus.exe_ready_i = 1'b0;
        offer(16'hA1, 32'hA);
        step();
        check("bp_A_valid", bus.exe_valid_o, 1);
        check("bp_A_ready", bus.issue_ready_o, 1);
        offer(16'hB2, 32'hB);
        step();
        bus.issue_valid_i = 1'b0;
        check("bp_full_ready", bus.issue_ready_o, 0);
        check("bp_full_oc", bus.exe_oc_o, 16'hA1);
        step();
        check("bp_hold_oc", bus.exe_oc_o, 16'hA1);
        check("bp_hold_src0", bus.exe_src0_o, 32'hA);
        check("bp_hold_ready", bus.issue_ready_o, 0);
        bus.exe_ready_i = 1'b1;
        step();
        check("bp_B_valid", bus.exe_valid_o, 1);
        check("bp_B_oc", bus.exe_oc_o, 16'hB2);
        check("bp_B_src0", bus.exe_src0_o, 32'hB);
        check("bp_B_ready", bus.issue_ready_o, 1);
        step();
        check("bp_empty_valid", bus.exe_valid_o, 0);

        // Flush with both entries full and a new offer pending.
        bus.exe_ready_i = 1'b0;
        offer(16'h0A, 32'h1); step();
        offer(16'h0B, 32'h2); step();
        check("fl_full_ready", bus.issue_ready_o, 0);
        offer(16'h0C, 32'h3);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        bus.issue_valid_i = 1'b0;
        bus.exe_ready_i = 1'b1;
        check("fl_exe_valid", bus.exe_valid_o, 0);
        check("fl_issue_ready", bus.issue_ready_o, 1);
        step();
        check("fl_no_capture", bus.exe_valid_o, 0);

        // Asynchronous reset between edges while main holds an entry.
        bus.exe_ready_i = 1'b0;
        offer(16'h5A, 32'h5A5A);
        step();
        bus.issue_valid_i = 1'b0;
        check("ar_pre_valid", bus.exe_valid_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_exe_valid", bus.exe_valid_o, 0);
        check("ar_issue_ready", bus.issue_ready_o, 1);
        check("ar_src0", bus.exe_src0_o, 0);
        step();
        #2;
        rst_n = 1'b1;
        bus.exe_ready_i = 1'b1;
        step();
        check("ar_after_valid", bus.exe_valid_o, 0);
        check("ar_after_ready", bus.issue_ready_o, 1);

        // Randomized traffic against the FIFO model.
        model_q.delete();
        for (int c = 0; c < 600; c++) begin
            check("rnd_ready", bus.issue_ready_o, model_q.size() < 2);
            check("rnd_valid", bus.exe_valid_o, model_q.size() > 0);
            if (model_q.size() > 0) begin
                check("rnd_src0", bus.exe_src0_o, model_q[0].s0);
                check("rnd_src1", bus.exe_src1_o, model_q[0].s1);
                check("rnd_pdest", bus.exe_pdest_o, model_q[0].pd);
                check("rnd_oc", bus.exe_oc_o, model_q[0].oc);
            end
            bus.issue_valid_i       = ($urandom % 4) != 0;
            bus.exe_ready_i         = ($urandom % 3) != 0;
            flush_i                 = ($urandom % 40) == 0;
            bus.issue_psrc0_i       = 6'($urandom_range(0, 7));
            bus.issue_psrc1_i       = 6'($urandom_range(0, 7));
            bus.issue_psrc0_valid_i = ($urandom % 5) != 0;
            bus.issue_psrc1_valid_i = ($urandom % 5) != 0;
            bus.issue_pdest_i       = 6'($urandom);
            bus.issue_oc_i          = 16'($urandom);
            bus.rf_rdata0_i         = $urandom;
            bus.rf_rdata1_i         = $urandom;
            bus.wb_i                = 4'($urandom);
            for (int j = 0; j < WB_WIDTH; j++) begin
                bus.wb_pdest_i[j*PREG_W +: PREG_W] = 6'($urandom_range(0, 7));
                bus.wb_data_i[j*DATA_W +: DATA_W]  = $urandom;
            end
            acc  = bus.issue_valid_i && (model_q.size() < 2);
            drn  = (model_q.size() > 0) && bus.exe_ready_i;
            e.s0 = ref_operand(bus.issue_psrc0_valid_i, bus.issue_psrc0_i, bus.rf_rdata0_i);
            e.s1 = ref_operand(bus.issue_psrc1_valid_i, bus.issue_psrc1_i, bus.rf_rdata1_i);
            e.pd = bus.issue_pdest_i;
            e.oc = bus.issue_oc_i;
            step();
            if (flush_i) begin
                model_q.delete();
            end else begin
                if (drn) void'(model_q.pop_front());
                if (acc) model_q.push_back(e);
            end
        end
        flush_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
